// File: rtl/db_chroma_edge_filter.sv
// HEVC chroma deblocking edge filter: two-stage pipeline that clips the
// weak-filter offset against the segment tc and emits filtered p0/q0 with framing.
module db_chroma_edge_filter #(
  parameter int SEG_LINES = 4,
  parameter int BIT_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_sos_i,
  input  logic [4:0]           tc_i,
  input  logic                 en_i,
  input  logic [BIT_DEPTH-1:0] p1_i,
  input  logic [BIT_DEPTH-1:0] p0_i,
  input  logic [BIT_DEPTH-1:0] q0_i,
  input  logic [BIT_DEPTH-1:0] q1_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [BIT_DEPTH-1:0] p0_o,
  output logic [BIT_DEPTH-1:0] q0_o,
  output logic                 out_sos_o,
  output logic                 out_eos_o
);

  localparam int W = BIT_DEPTH + 4;
  localparam logic [3:0] SEG_LAST = 4'(SEG_LINES);
  localparam logic signed [W-1:0] ROUND = W'(4);
  localparam logic signed [W-1:0] PIX_MAX = {{(W-BIT_DEPTH){1'b0}}, {BIT_DEPTH{1'b1}}};

  // Pipeline control
  logic w_s1_adv, w_s2_adv, w_accept;
  logic r_s1_v, r_s2_v;

  assign w_s2_adv   = !r_s2_v || out_ready_i;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign in_ready_o = w_s1_adv;
  assign w_accept   = in_valid_i && w_s1_adv;

  // Segment tracking
  logic [2:0] r_line_cnt;
  logic [4:0] r_seg_tc;
  logic       r_seg_en;
  logic       w_sos_eff, w_eos, w_en;
  logic [3:0] w_cnt_inc;
  logic [4:0] w_tc;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_sos_eff = in_sos_i || (r_line_cnt == 3'd0);
    w_cnt_inc = 4'd1;
    if (!w_sos_eff) w_cnt_inc = {1'b0, r_line_cnt} + 4'd1;
    w_eos = (w_cnt_inc == SEG_LAST);
    w_tc  = in_sos_i ? tc_i : r_seg_tc;
    w_en  = in_sos_i ? en_i : r_seg_en;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_cnt <= 3'd0;
      r_seg_tc   <= 5'd0;
      r_seg_en   <= 1'b0;
    end else if (w_accept) begin
      r_line_cnt <= w_eos ? 3'd0 : w_cnt_inc[2:0];
      if (in_sos_i) begin
        r_seg_tc <= tc_i;
        r_seg_en <= en_i;
      end
    end
  end

  // Stage 1: raw offset, floor division by 8 via arithmetic shift
  logic signed [W-1:0] w_p1_s, w_p0_s, w_q0_s, w_q1_s, w_sum, w_raw;

  assign w_p1_s = $signed({{(W-BIT_DEPTH){1'b0}}, p1_i});
  assign w_p0_s = $signed({{(W-BIT_DEPTH){1'b0}}, p0_i});
  assign w_q0_s = $signed({{(W-BIT_DEPTH){1'b0}}, q0_i});
  assign w_q1_s = $signed({{(W-BIT_DEPTH){1'b0}}, q1_i});
  assign w_sum  = ((w_q0_s - w_p0_s) <<< 2) + w_p1_s - w_q1_s + ROUND;
  assign w_raw  = w_sum >>> 3;

  logic signed [W-1:0]  r_s1_raw;
  logic [BIT_DEPTH-1:0] r_s1_p0, r_s1_q0;
  logic [4:0]           r_s1_tc;
  logic                 r_s1_en, r_s1_sos, r_s1_eos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_raw <= '0;
      r_s1_p0  <= '0;
      r_s1_q0  <= '0;
      r_s1_tc  <= 5'd0;
      r_s1_en  <= 1'b0;
      r_s1_sos <= 1'b0;
      r_s1_eos <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid_i;
      if (in_valid_i) begin
        r_s1_raw <= w_raw;
        r_s1_p0  <= p0_i;
        r_s1_q0  <= q0_i;
        r_s1_tc  <= w_tc;
        r_s1_en  <= w_en;
        r_s1_sos <= w_sos_eff;
        r_s1_eos <= w_eos;
      end
    end
  end

  // Stage 2: clip offset to +-tc, apply, clamp to sample range
  function automatic logic [BIT_DEPTH-1:0] clip_pix(input logic signed [W-1:0] v);
    if (v[W-1])         return '0;
    else if (v > PIX_MAX) return '1;
    else                return v[BIT_DEPTH-1:0];
  endfunction

  logic signed [W-1:0]  w_tc_s, w_delta, w_p0_sum, w_q0_sum;
  logic                 w_bypass;
  logic [BIT_DEPTH-1:0] w_p0_f, w_q0_f;

  always_comb begin
    w_tc_s  = $signed({{(W-5){1'b0}}, r_s1_tc});
    w_delta = r_s1_raw;
    if (r_s1_raw > w_tc_s)       w_delta = w_tc_s;
    else if (r_s1_raw < -w_tc_s) w_delta = -w_tc_s;
    w_p0_sum = $signed({{(W-BIT_DEPTH){1'b0}}, r_s1_p0}) + w_delta;
    w_q0_sum = $signed({{(W-BIT_DEPTH){1'b0}}, r_s1_q0}) - w_delta;
    w_bypass = !r_s1_en || (r_s1_tc == 5'd0);
    w_p0_f   = w_bypass ? r_s1_p0 : clip_pix(w_p0_sum);
    w_q0_f   = w_bypass ? r_s1_q0 : clip_pix(w_q0_sum);
  end

  logic [BIT_DEPTH-1:0] r_s2_p0, r_s2_q0;
  logic                 r_s2_sos, r_s2_eos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v   <= 1'b0;
      r_s2_p0  <= '0;
      r_s2_q0  <= '0;
      r_s2_sos <= 1'b0;
      r_s2_eos <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_p0  <= w_p0_f;
        r_s2_q0  <= w_q0_f;
        r_s2_sos <= r_s1_sos;
        r_s2_eos <= r_s1_eos;
      end
    end
  end

  assign out_valid_o = r_s2_v;
  assign p0_o        = r_s2_p0;
  assign q0_o        = r_s2_q0;
  assign out_sos_o   = r_s2_sos;
  assign out_eos_o   = r_s2_eos;

endmodule
